// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM state encoding,
// flag bit positions and the writable-opcode test.
// Optional feature macro: ALU_DIV_EN (enables opcode 9, unsigned divide).
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOT = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_MUL = 4'd8,
        OP_DIV = 4'd9
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EXEC = 3'd1,
        ST_MUL  = 3'd2,
        ST_DIV  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Bit positions inside the {Z,N,C,V} flag word
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Opcodes that produce a register-file write and update the flags
    function automatic logic WRITABLE(input logic [3:0] o);
`ifdef ALU_DIV_EN
        return (o <= OP_DIV);
`else
        return (o <= OP_MUL);
`endif
    endfunction

endpackage

// File: rtl/alu_iter_core.sv
// Iterative datapath shared by multiply and divide. The {hi,lo} register
// pair holds the accumulator/product for MUL and remainder/quotient for DIV;
// one step is performed per cycle while the FSM holds step high.
// Optional feature macro: ALU_DIV_EN (adds the restoring-divide step).
module alu_iter_core
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         nRESET,
    input  logic         load,
    input  logic         step,
`ifdef ALU_DIV_EN
    input  logic         is_div,
`endif
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    logic [W-1:0] hi_reg, lo_reg;
    logic [W-1:0] hi_next, lo_next;
    logic [W:0]   mul_sum;
`ifdef ALU_DIV_EN
    logic [W:0]   rem_sh;
    logic         div_ge;
`endif

    // One iteration: shift-add multiply by default, restoring divide when selected
    always_comb begin
        // Add the multiplicand when the current multiplier LSB is set, then
        // shift the whole product pair right, carry entering at the top.
        mul_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b} : '0);
        hi_next = mul_sum[W:1];
        lo_next = {mul_sum[0], lo_reg[W-1:1]};
`ifdef ALU_DIV_EN
        // Shift the next dividend bit into the remainder and try subtracting.
        // A zero divisor always "fits", which yields an all-ones quotient.
        rem_sh = {hi_reg, lo_reg[W-1]};
        div_ge = (rem_sh >= {1'b0, b});
        if (is_div) begin
            hi_next = div_ge ? W'(rem_sh - {1'b0, b}) : rem_sh[W-1:0];
            lo_next = {lo_reg[W-2:0], div_ge};
        end
`endif
    end

    // Accumulator pair: cleared on load with the first operand in lo, stepped under FSM control
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (load) begin
            hi_reg <= '0;
            lo_reg <= a;
        end else if (step) begin
            hi_reg <= hi_next;
            lo_reg <= lo_next;
        end
    end

    assign hi = hi_reg;
    assign lo = lo_reg;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU between the register file read ports and its write port.
// Single-cycle ops go IDLE->EXEC->DONE; MUL (and DIV) spend ITER step cycles
// plus one settle cycle in their loop state before DONE. Results and flags
// are registered on entry to DONE and held until the next completion.
// Optional feature macro: ALU_DIV_EN (opcode 9 divides; otherwise reserved).
module alu_seq
    import alu_pkg::*;
#(
    parameter int W    = 8,
    parameter int AW   = 4,
    parameter int ITER = W
) (
    input  logic          CLK,
    input  logic          nRESET,
    input  logic          start,
    input  logic [3:0]    op,
    input  logic [W-1:0]  RD1,
    input  logic [W-1:0]  RD2,
    input  logic [AW-1:0] WA_in,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  ALUResult,
    output logic          write_enable,
    output logic [AW-1:0] WA,
    output logic [3:0]    flags
);

    localparam logic [2:0] S_IDLE = ST_IDLE;
    localparam logic [2:0] S_EXEC = ST_EXEC;
    localparam logic [2:0] S_MUL  = ST_MUL;
    localparam logic [2:0] S_DIV  = ST_DIV;
    localparam logic [2:0] S_DONE = ST_DONE;

    localparam int            CW       = $clog2(ITER + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ITER);

    logic [2:0]    state_reg, state_next;
    logic [3:0]    op_reg;
    logic [W-1:0]  a_reg, b_reg;
    logic [AW-1:0] wa_reg;
    logic [CW-1:0] cnt_reg;
    logic [W-1:0]  result_reg;
    logic [3:0]    flags_reg;

    logic          accept, in_loop, step, finish;
    logic [W-1:0]  core_hi, core_lo;
    logic [W:0]    sum, diff;
    logic [W-1:0]  res_c;
    logic          c_c, v_c;
    logic [3:0]    flags_c;

    assign accept  = start && (state_reg == S_IDLE);
    assign in_loop = (state_reg == S_MUL) || (state_reg == S_DIV);
    // The last loop cycle (cnt == ITER) only lets the final step settle
    assign step    = in_loop && (cnt_reg != CNT_LAST);
    assign finish  = (state_next == S_DONE);

    // Next-state decode; start outside IDLE is simply ignored
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        state_next = S_MUL;
`ifdef ALU_DIV_EN
                    end else if (op == OP_DIV) begin
                        state_next = S_DIV;
`endif
                    end else begin
                        state_next = S_EXEC;
                    end
                end
            end
            S_EXEC:        state_next = S_DONE;
            S_MUL, S_DIV:  if (cnt_reg == CNT_LAST) state_next = S_DONE;
            S_DONE:        state_next = S_IDLE;
            default:       state_next = S_IDLE;
        endcase
    end

    // FSM state, operand latches and loop counter
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_reg <= S_IDLE;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            wa_reg    <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg  <= op;
                a_reg   <= RD1;
                b_reg   <= RD2;
                wa_reg  <= WA_in;
                cnt_reg <= '0;
            end else if (in_loop && (cnt_reg != CNT_LAST)) begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

    alu_iter_core #(.W(W)) u_core (
        .CLK    (CLK),
        .nRESET (nRESET),
        .load   (accept),
        .step   (step),
`ifdef ALU_DIV_EN
        .is_div (state_reg == S_DIV),
`endif
        .a      (RD1),
        .b      (b_reg),
        .hi     (core_hi),
        .lo     (core_lo)
    );

    // Result and flag computation from the latched operands / loop output
    always_comb begin
        sum     = {1'b0, a_reg} + {1'b0, b_reg};
        diff    = {1'b0, a_reg} - {1'b0, b_reg};
        res_c   = result_reg;
        c_c     = 1'b0;
        v_c     = 1'b0;
        case (op_reg)
            OP_ADD: begin
                res_c = sum[W-1:0];
                c_c   = sum[W];
                v_c   = (a_reg[W-1] == b_reg[W-1]) && (sum[W-1] != a_reg[W-1]);
            end
            OP_SUB: begin
                res_c = diff[W-1:0];
                c_c   = diff[W];
                v_c   = (a_reg[W-1] != b_reg[W-1]) && (diff[W-1] != a_reg[W-1]);
            end
            OP_AND: res_c = a_reg & b_reg;
            OP_OR:  res_c = a_reg | b_reg;
            OP_XOR: res_c = a_reg ^ b_reg;
            OP_NOT: res_c = ~a_reg;
            OP_SHL: begin
                res_c = {a_reg[W-2:0], 1'b0};
                c_c   = a_reg[W-1];
            end
            OP_SHR: begin
                res_c = {1'b0, a_reg[W-1:1]};
                c_c   = a_reg[0];
            end
            OP_MUL: begin
                res_c = core_lo;
                c_c   = (core_hi != '0);
            end
`ifdef ALU_DIV_EN
            OP_DIV: begin
                res_c = (b_reg == '0) ? '1 : core_lo;
                v_c   = (b_reg == '0);
            end
`endif
            default: ;
        endcase
        flags_c         = '0;
        flags_c[FLAG_Z] = (res_c == '0);
        flags_c[FLAG_N] = res_c[W-1];
        flags_c[FLAG_C] = c_c;
        flags_c[FLAG_V] = v_c;
    end

    // Result/flag registers: loaded only when a writable op completes
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            result_reg <= '0;
            flags_reg  <= '0;
        end else if (finish && WRITABLE(op_reg)) begin
            result_reg <= res_c;
            flags_reg  <= flags_c;
        end
    end

    assign busy         = (state_reg != S_IDLE);
    assign done         = (state_reg == S_DONE);
    assign write_enable = done && WRITABLE(op_reg);
    assign WA           = wa_reg;
    assign ALUResult    = result_reg;
    assign flags        = flags_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: a reference model pushes the expected
// completion of each issued op into a queue, and each test pops and compares
// when the DUT signals done. Honours ALU_DIV_EN when defined.
`timescale 1ns/1ps
module tb_alu_seq;

    localparam int W     = 8;
    localparam int AW    = 4;
    localparam int ITER  = 8;
    localparam int BOUND = 40;
`ifdef ALU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic          CLK    = 1'b0;
    logic          nRESET = 1'b0;
    logic          start  = 1'b0;
    logic [3:0]    op     = '0;
    logic [W-1:0]  RD1    = '0;
    logic [W-1:0]  RD2    = '0;
    logic [AW-1:0] WA_in  = '0;
    logic          busy, done, write_enable;
    logic [W-1:0]  ALUResult;
    logic [AW-1:0] WA;
    logic [3:0]    flags;

    typedef struct packed {
        logic [7:0] res;
        logic [3:0] flags;
        logic       we;
        logic [3:0] wa;
        logic [7:0] lat;
        logic       bacc;
        logic       bpost;
    } txn_t;

    txn_t       sb[$];
    logic [7:0] m_res   = '0;
    logic [3:0] m_flags = '0;
    int         vectors     = 0;
    int         miscompares = 0;

    alu_seq #(.W(W), .AW(AW), .ITER(ITER)) dut (
        .CLK          (CLK),
        .nRESET       (nRESET),
        .start        (start),
        .op           (op),
        .RD1          (RD1),
        .RD2          (RD2),
        .WA_in        (WA_in),
        .busy         (busy),
        .done         (done),
        .ALUResult    (ALUResult),
        .write_enable (write_enable),
        .WA           (WA),
        .flags        (flags)
    );

    always #5 CLK = ~CLK;

    function automatic string fmt(input txn_t t);
        return $sformatf("res=%h flags=%b we=%b wa=%h lat=%0d busy_acc=%b busy_post=%b",
                         t.res, t.flags, t.we, t.wa, t.lat, t.bacc, t.bpost);
    endfunction

    // Reference model: computes the expected completion and queues it
    function automatic void push_model(input logic [3:0] o, input logic [7:0] a,
                                       input logic [7:0] b, input logic [3:0] wa);
        txn_t        e;
        logic [15:0] p;
        int          sa, sbv;
        logic [7:0]  r;
        logic        c, v, wr;
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        p   = {8'h00, a} * {8'h00, b};
        r   = '0;
        c   = 1'b0;
        v   = 1'b0;
        wr  = 1'b1;
        case (o)
            4'd0: begin r = a + b; c = ({1'b0, a} + {1'b0, b}) > 9'd255;
                        v = (sa + sbv > 127) || (sa + sbv < -128); end
            4'd1: begin r = a - b; c = (a < b);
                        v = (sa - sbv > 127) || (sa - sbv < -128); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~a;
            4'd6: begin r = {a[6:0], 1'b0}; c = a[7]; end
            4'd7: begin r = {1'b0, a[7:1]}; c = a[0]; end
            4'd8: begin r = p[7:0]; c = (p[15:8] != 8'h00); end
            4'd9: begin
                if (DIV_EN) begin
                    if (b == 8'h00) begin r = 8'hFF; v = 1'b1; end
                    else r = a / b;
                end else wr = 1'b0;
            end
            default: wr = 1'b0;
        endcase
        if (wr) begin
            m_res   = r;
            m_flags = {(r == 8'h00), r[7], c, v};
        end
        e.res   = m_res;
        e.flags = m_flags;
        e.we    = wr;
        e.wa    = wa;
        e.lat   = (o == 4'd8 || (o == 4'd9 && DIV_EN)) ? 8'd10 : 8'd2;
        e.bacc  = 1'b1;
        e.bpost = 1'b0;
        sb.push_back(e);
    endfunction

    // Issue one op, wait (bounded) for done, capture what the DUT produced
    task automatic do_op(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] wa, output txn_t obs);
        int lat;
        @(negedge CLK);
        op = o; RD1 = a; RD2 = b; WA_in = wa; start = 1'b1;
        push_model(o, a, b, wa);
        @(posedge CLK); #1;
        start    = 1'b0;
        obs      = '0;
        obs.bacc = busy;
        lat      = 1;
        while (!done && lat < BOUND) begin
            @(posedge CLK); #1;
            lat++;
        end
        obs.res   = ALUResult;
        obs.flags = flags;
        obs.we    = write_enable;
        obs.wa    = WA;
        obs.lat   = 8'(lat);
        @(posedge CLK); #1;
        obs.bpost = busy;
        $display("op=%h a=%h b=%h wa=%h : %s", o, a, b, wa, fmt(obs));
    endtask

    task automatic test_reset();
        nRESET = 1'b0;
        #12;
        vectors++;
        if ({busy, done, write_enable, ALUResult, WA, flags} !== '0) begin
            miscompares++;
            $display("FAIL reset: got busy=%b done=%b we=%b res=%h wa=%h flags=%b, want all 0",
                     busy, done, write_enable, ALUResult, WA, flags);
        end
        @(negedge CLK);
        nRESET = 1'b1;
        m_res = '0; m_flags = '0;
    endtask

    task automatic test_logic();
        logic [23:0] tbl [0:11] = '{24'h07F013, 24'h105051, 24'h103052, 24'h0FF014,
                                    24'h2F03C5, 24'h3F00F6, 24'h4AAFF7, 24'h50F008,
                                    24'h681009, 24'h78100A, 24'hC12340, 24'h180010};
        txn_t obs, want;
        for (int i = 0; i < 12; i++) begin
            do_op(tbl[i][23:20], tbl[i][19:12], tbl[i][11:4], tbl[i][3:0], obs);
            want = sb.pop_front();
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL logic[%0d]: got %s, want %s", i, fmt(obs), fmt(want));
            end
        end
    endtask

    task automatic test_mul();
        logic [23:0] tbl [0:3] = '{24'h810111, 24'h80F032, 24'h8FFFF3, 24'h800554};
        txn_t obs, want;
        for (int i = 0; i < 4; i++) begin
            do_op(tbl[i][23:20], tbl[i][19:12], tbl[i][11:4], tbl[i][3:0], obs);
            want = sb.pop_front();
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL mul[%0d]: got %s, want %s", i, fmt(obs), fmt(want));
            end
        end
    endtask

    task automatic test_div();
        logic [23:0] tbl [0:3] = '{24'h9C8075, 24'h964006, 24'h907C87, 24'h9FF018};
        txn_t obs, want;
        for (int i = 0; i < 4; i++) begin
            do_op(tbl[i][23:20], tbl[i][19:12], tbl[i][11:4], tbl[i][3:0], obs);
            want = sb.pop_front();
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL div[%0d]: got %s, want %s", i, fmt(obs), fmt(want));
            end
        end
    endtask

    // start stays high through a MUL: exactly one completion expected
    task automatic test_start_held();
        txn_t obs, want;
        int   lat, dones;
        @(negedge CLK);
        op = 4'd8; RD1 = 8'h0F; RD2 = 8'h11; WA_in = 4'h9; start = 1'b1;
        push_model(4'd8, 8'h0F, 8'h11, 4'h9);
        @(posedge CLK); #1;
        obs = '0; obs.bacc = busy; obs.bpost = 1'b0;
        lat = 1; dones = 0;
        repeat (20) begin
            @(posedge CLK); #1;
            lat++;
            if (done) begin
                dones++;
                if (dones == 1) begin
                    obs.res = ALUResult; obs.flags = flags; obs.we = write_enable;
                    obs.wa  = WA; obs.lat = 8'(lat);
                    start   = 1'b0;
                end
            end
        end
        start = 1'b0;
        want = sb.pop_front();
        $display("start held MUL : %s dones=%0d", fmt(obs), dones);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL held_result: got %s, want %s", fmt(obs), fmt(want));
        end
        vectors++;
        if (dones != 1) begin
            miscompares++;
            $display("FAIL held_done_count: got %0d, want 1", dones);
        end
    endtask

    // New op presented while in DONE: ignored there, accepted the next cycle
    task automatic test_back_to_back();
        txn_t want;
        int   lat;
        @(negedge CLK);
        op = 4'd0; RD1 = 8'h11; RD2 = 8'h22; WA_in = 4'h5; start = 1'b1;
        push_model(4'd0, 8'h11, 8'h22, 4'h5);
        @(posedge CLK); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < BOUND) begin
            @(posedge CLK); #1;
            lat++;
        end
        want = sb.pop_front();
        $display("b2b first : res=%h flags=%b we=%b wa=%h lat=%0d", ALUResult, flags, write_enable, WA, lat);
        vectors++;
        if ({ALUResult, flags, write_enable, WA, 8'(lat)} !== {want.res, want.flags, want.we, want.wa, want.lat}) begin
            miscompares++;
            $display("FAIL b2b_first: got res=%h flags=%b we=%b wa=%h lat=%0d, want %s",
                     ALUResult, flags, write_enable, WA, lat, fmt(want));
        end
        op = 4'd4; RD1 = 8'h3C; RD2 = 8'h0F; WA_in = 4'h6; start = 1'b1;
        push_model(4'd4, 8'h3C, 8'h0F, 4'h6);
        lat = 0;
        @(posedge CLK); #1;
        lat++;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_busy_drop: got busy=%b, want 0", busy);
        end
        @(posedge CLK); #1;
        lat++;
        start = 1'b0;
        while (!done && lat < BOUND) begin
            @(posedge CLK); #1;
            lat++;
        end
        want = sb.pop_front();
        $display("b2b second : res=%h flags=%b we=%b wa=%h lat=%0d", ALUResult, flags, write_enable, WA, lat);
        vectors++;
        if ({ALUResult, flags, write_enable, WA, 8'(lat)} !== {want.res, want.flags, want.we, want.wa, want.lat + 8'd1}) begin
            miscompares++;
            $display("FAIL b2b_second: got res=%h flags=%b we=%b wa=%h lat=%0d, want %s (+1 lat)",
                     ALUResult, flags, write_enable, WA, lat, fmt(want));
        end
        @(posedge CLK); #1;
    endtask

    // Asynchronous reset in the middle of a MUL aborts it with no write
    task automatic test_reset_mid();
        txn_t obs, want;
        int   dones;
        @(negedge CLK);
        op = 4'd8; RD1 = 8'hFF; RD2 = 8'hFF; WA_in = 4'hA; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (4) @(posedge CLK);
        #2;
        nRESET = 1'b0;
        #1;
        $display("reset mid-MUL : busy=%b done=%b we=%b res=%h wa=%h flags=%b",
                 busy, done, write_enable, ALUResult, WA, flags);
        vectors++;
        if ({busy, done, write_enable, ALUResult, WA, flags} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got busy=%b done=%b we=%b res=%h wa=%h flags=%b, want all 0",
                     busy, done, write_enable, ALUResult, WA, flags);
        end
        dones = 0;
        repeat (3) begin
            @(posedge CLK); #1;
            if (done || write_enable) dones++;
        end
        @(negedge CLK);
        nRESET = 1'b1;
        m_res = '0; m_flags = '0;
        repeat (14) begin
            @(posedge CLK); #1;
            if (done || write_enable || busy) dones++;
        end
        vectors++;
        if (dones != 0) begin
            miscompares++;
            $display("FAIL reset_mid_no_done: got %0d active cycles, want 0", dones);
        end
        do_op(4'd0, 8'h20, 8'h22, 4'hB, obs);
        want = sb.pop_front();
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL reset_mid_fresh_add: got %s, want %s", fmt(obs), fmt(want));
        end
    endtask

    initial begin
        test_reset();
        test_logic();
        test_mul();
        test_div();
        test_start_held();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
